lcd_write_ctrl: RTL and testbench
=================================

# lcd_write_ctrl

Parametrised write-only controller for an HD44780-class character LCD. It is the successor to the fixed 8-bit rs/rw/enable/data LCD port in the current system. Commands and characters are accepted from the system side over a valid/ready handshake and buffered in a small FIFO. The block then replays each entry onto the LCD pins with cycle-counted setup, enable-pulse, hold and execution delays. It adds a 4-bit bus mode, a parametrised FIFO depth and a long-wait path for clear/home commands.

## Interface
Parameters:
- BUS_W, 8: LCD data bus width; 8 or 4.
- FIFO_DEPTH, 16: command FIFO entries; power of 2, at least 2.
- T_AS, 4: cycles from rs/data stable to lcd_en rising; at least 1.
- T_EN, 12: cycles lcd_en stays high; at least 1.
- T_H, 2: cycles rs/data are held after lcd_en falls; at least 1.
- T_EXEC, 2000: idle cycles after a normal command or character.
- T_CLR, 82000: idle cycles after clear (0x01) or home (0x02/0x03) with rs=0.

Ports:
- clk_clk, in, 1: single clock.
- reset_reset, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: entry offered.
- cmd_ready, out, 1: FIFO not full and not in reset.
- cmd_rs, in, 1: 0 = instruction, 1 = data.
- cmd_half, in, 1: 4-bit mode only; send the high nibble alone. Ignored when BUS_W=8.
- cmd_data, in, 8: byte to write.
- lcd_rs, out, 1: register select.
- lcd_rw, out, 1: tied 0; write-only.
- lcd_en, out, 1: enable strobe.
- lcd_data, out, BUS_W: data bus (DB7..DB0, or DB7..DB4 in 4-bit mode).
- busy, out, 1: FSM not IDLE, or FIFO non-empty.
- fifo_level, out, clog2(FIFO_DEPTH)+1: entries currently stored.

## Operation
- A push happens when cmd_valid and cmd_ready are both high. Each entry stores {rs, half, data}, 10 bits.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
- IDLE: if the FIFO is non-empty, pop one entry. Load lcd_rs and lcd_data (BUS_W=8: the full byte; BUS_W=4: data[7:4]) and go to SETUP.
- SETUP: hold for T_AS cycles, then go to PULSE.
- PULSE: lcd_en=1 for T_EN cycles, then go to HOLD.
- HOLD: hold rs/data for T_H cycles. Then:
  - if BUS_W=4, the current nibble is the high one, and half=0: load data[3:0] and return to SETUP.
  - otherwise go to WAIT.
- WAIT: idle for T_CLR cycles if rs=0 and data[7:1] is 0000000 or 0000001; otherwise idle for T_EXEC cycles. Then return to IDLE.
- lcd_rs and lcd_data keep their last value in WAIT and IDLE. lcd_en is high only in PULSE.
- The delay counter is a single down-counter sized to clog2(max(T_AS,T_EN,T_H,T_EXEC,T_CLR)+1) bits.

## Timing
- Reset values: cmd_ready, lcd_rs, lcd_rw, lcd_en, lcd_data, busy and fifo_level are all 0. The FIFO is empty and the FSM is in IDLE.
- cmd_ready rises in the first cycle after reset deasserts.
- Latency: push into an empty FIFO at edge N. The entry is visible at N+1. IDLE pops it and loads the pins at edge N+2. lcd_en is first high in cycle N+2+T_AS, which is N+6 with defaults.
- The FIFO is full when fifo_level equals FIFO_DEPTH. cmd_ready is combinational on !full.
- Pushing while full is impossible, because cmd_ready is low.
- Simultaneous push and pop keeps fifo_level unchanged. This holds at every level, including 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level uses the extra MSB to distinguish full from empty.
- Reset mid-operation: at the next edge lcd_en drops to 0, all pending entries are discarded, and the in-flight WAIT is abandoned.
- busy falls in the first cycle after WAIT completes, and only if the FIFO is empty.

## Structure
- Package lcd_pkg holds:
  - the FSM state enum;
  - the opcode constants LCD_CLR=8'h01 and LCD_HOME=8'h02;
  - the entry struct {rs, half, data};
  - the default timing constants for a 50 MHz clock.
- Sub-module lcd_cmd_fifo: synchronous FIFO with parameter DEPTH and a parameter for data width. It has push/pop/full/empty/level ports and no read latency (show-ahead).

## Test plan
- 8-bit data write with default parameters: push rs=1, data=0x41 at edge N.
  - lcd_rs=1 and lcd_data=0x41 from N+2.
  - lcd_en high in cycles N+6 through N+17.
  - busy low after T_H+T_EXEC more cycles.
- Clear then character: push {0,0x01} then {1,0x48}.
  - The second lcd_en rise is exactly T_H+T_CLR+1+T_AS cycles after the first pulse ends.
  - With {0,0x38} in place of the clear, the gap uses T_EXEC instead.
- FIFO full, DEPTH=16: drive cmd_valid continuously for 20 cycles.
  - 17 entries are accepted (one is popped early), then cmd_ready stays low.
  - All 17 appear on lcd_data in order.
- 4-bit mode (BUS_W=4):
  - push {1,0x3C}: two enable pulses, lcd_data=0x3 then 0xC, separated by T_H+T_AS low cycles.
  - push {0,half=1,0x30}: a single pulse carrying 0x3.
- Reset mid-pulse: assert reset_reset while in PULSE with 3 entries queued.
  - Next cycle: lcd_en=0, fifo_level=0, busy=0.
  - No further pulses occur.
- Push/pop at level 1: with one entry queued and the FSM in IDLE, push a new entry.
  - fifo_level stays 1 and both entries are emitted in order.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, opcodes and default timing for the LCD write controller
package lcd_pkg;

  typedef enum logic [2:0] {
    LCD_ST_IDLE  = 3'd0,
    LCD_ST_SETUP = 3'd1,
    LCD_ST_PULSE = 3'd2,
    LCD_ST_HOLD  = 3'd3,
    LCD_ST_WAIT  = 3'd4
  } lcd_state_e;

  localparam logic [7:0] LCD_CLR  = 8'h01;
  localparam logic [7:0] LCD_HOME = 8'h02;

  typedef struct packed {
    logic       rs;
    logic       half;
    logic [7:0] data;
  } lcd_entry_t;

  localparam int LCD_ENTRY_W = $bits(lcd_entry_t);

  // 50 MHz clock: 80 ns setup, 240 ns enable, 40 ns hold, 40 us execute, 1.64 ms clear/home
  localparam int LCD_T_AS   = 4;
  localparam int LCD_T_EN   = 12;
  localparam int LCD_T_H    = 2;
  localparam int LCD_T_EXEC = 2000;
  localparam int LCD_T_CLR  = 82000;

  // Clear (0x01) and home (0x02/0x03) instructions need the long execution wait
  function automatic logic is_long_cmd(input lcd_entry_t e);
    return !e.rs && ((e.data[7:1] == LCD_CLR[7:1]) || (e.data[7:1] == LCD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - show-ahead synchronous FIFO buffering LCD commands
module lcd_cmd_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra MSB so equal low bits with differing MSB means full
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset discards every stored entry
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between the pointers so need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_write_ctrl.sv
// rtl/lcd_write_ctrl.sv - buffered write-only HD44780 controller with 8/4-bit bus timing
module lcd_write_ctrl
  import lcd_pkg::*;
#(
  parameter int BUS_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int T_AS       = LCD_T_AS,
  parameter int T_EN       = LCD_T_EN,
  parameter int T_H        = LCD_T_H,
  parameter int T_EXEC     = LCD_T_EXEC,
  parameter int T_CLR      = LCD_T_CLR
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rs,
  input  logic                          cmd_half,
  input  logic [7:0]                    cmd_data,
  output logic                          lcd_rs,
  output logic                          lcd_rw,
  output logic                          lcd_en,
  output logic [BUS_W-1:0]              lcd_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int T_M1  = (T_AS > T_EN) ? T_AS : T_EN;
  localparam int T_M2  = (T_M1 > T_H) ? T_M1 : T_H;
  localparam int T_M3  = (T_M2 > T_EXEC) ? T_M2 : T_EXEC;
  localparam int T_MAX = (T_M3 > T_CLR) ? T_M3 : T_CLR;
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_AS   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] CNT_EN   = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] CNT_H    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] CNT_EXEC = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] CNT_CLR  = CNT_W'(T_CLR - 1);

  localparam logic [2:0] ST_IDLE  = LCD_ST_IDLE;
  localparam logic [2:0] ST_SETUP = LCD_ST_SETUP;
  localparam logic [2:0] ST_PULSE = LCD_ST_PULSE;
  localparam logic [2:0] ST_HOLD  = LCD_ST_HOLD;
  localparam logic [2:0] ST_WAIT  = LCD_ST_WAIT;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  lcd_entry_t       cur;
  lcd_entry_t       head;
  lcd_entry_t       wr_entry;
  logic             hi_nib;
  logic             seen;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // First beat is the whole byte on an 8-bit bus, the high nibble on a 4-bit bus
  function automatic logic [BUS_W-1:0] first_beat(input logic [7:0] d);
    if (BUS_W == 8) return BUS_W'(d);
    else            return BUS_W'(d[7:4]);
  endfunction

  assign cmd_ready = !full && !reset_reset;
  assign push      = cmd_valid && cmd_ready;
  assign wr_entry  = '{rs: cmd_rs, half: cmd_half, data: cmd_data};
  // The FSM acts on an entry only once it has sat in the FIFO for a full cycle
  assign pop       = (state == ST_IDLE) && seen && !empty;
  assign busy      = (state != ST_IDLE) || !empty;
  assign lcd_rw    = 1'b0;

  lcd_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (LCD_ENTRY_W)
  ) u_fifo (
    .clk   (clk_clk),
    .reset (reset_reset),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Replay FSM: setup, enable pulse, hold, optional second nibble, then execution wait
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur      <= '0;
      hi_nib   <= 1'b0;
      seen     <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_data <= '0;
    end else begin
      seen <= !empty;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur      <= head;
            lcd_rs   <= head.rs;
            lcd_data <= first_beat(head.data);
            hi_nib   <= (BUS_W == 4);
            cnt      <= CNT_AS;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= CNT_EN;
            state  <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= CNT_H;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            if ((BUS_W == 4) && hi_nib && !cur.half) begin
              lcd_data <= BUS_W'(cur.data[3:0]);
              hi_nib   <= 1'b0;
              cnt      <= CNT_AS;
              state    <= ST_SETUP;
            end else begin
              cnt   <= is_long_cmd(cur) ? CNT_CLR : CNT_EXEC;
              state <= ST_WAIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// tb/tb_lcd_write_ctrl.sv - directed checks for lcd_write_ctrl in 8-bit and 4-bit bus modes
module tb_lcd_write_ctrl;

  localparam int T_AS   = 4;
  localparam int T_EN   = 12;
  localparam int T_H    = 2;
  localparam int T_EXEC = 20;
  localparam int T_CLR  = 60;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // Edge counter: after posedge k the negedge sees cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  logic       v8 = 1'b0, rs8i = 1'b0, half8 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic       ready8, lrs8, lrw8, len8, busy8;
  logic [7:0] ldat8;
  logic [4:0] lvl8;

  logic       v4 = 1'b0, rs4i = 1'b0, half4 = 1'b0;
  logic [7:0] d4 = 8'h00;
  logic       ready4, lrs4, lrw4, len4, busy4;
  logic [3:0] ldat4;
  logic [4:0] lvl4;

  lcd_write_ctrl #(
    .BUS_W(8), .FIFO_DEPTH(DEPTH), .T_AS(T_AS), .T_EN(T_EN),
    .T_H(T_H), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
  ) u_lcd8 (
    .clk_clk(clk), .reset_reset(rst), .cmd_valid(v8), .cmd_ready(ready8),
    .cmd_rs(rs8i), .cmd_half(half8), .cmd_data(d8), .lcd_rs(lrs8), .lcd_rw(lrw8),
    .lcd_en(len8), .lcd_data(ldat8), .busy(busy8), .fifo_level(lvl8)
  );

  lcd_write_ctrl #(
    .BUS_W(4), .FIFO_DEPTH(DEPTH), .T_AS(T_AS), .T_EN(T_EN),
    .T_H(T_H), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
  ) u_lcd4 (
    .clk_clk(clk), .reset_reset(rst), .cmd_valid(v4), .cmd_ready(ready4),
    .cmd_rs(rs4i), .cmd_half(half4), .cmd_data(d4), .lcd_rs(lrs4), .lcd_rw(lrw4),
    .lcd_en(len4), .lcd_data(ldat4), .busy(busy4), .fifo_level(lvl4)
  );

  int         r8_cyc[$];
  logic [7:0] r8_dat[$];
  int         f8_cyc[$];
  logic       en8_q = 1'b0;
  int         r4_cyc[$];
  logic [3:0] r4_dat[$];
  int         f4_cyc[$];
  logic       en4_q = 1'b0;

  // Log enable rise (with bus value) and fall cycles for both instances
  always @(negedge clk) begin
    if (len8 === 1'b1 && en8_q === 1'b0) begin r8_cyc.push_back(cyc); r8_dat.push_back(ldat8); end
    if (len8 === 1'b0 && en8_q === 1'b1) f8_cyc.push_back(cyc);
    if (len4 === 1'b1 && en4_q === 1'b0) begin r4_cyc.push_back(cyc); r4_dat.push_back(ldat4); end
    if (len4 === 1'b0 && en4_q === 1'b1) f4_cyc.push_back(cyc);
    en8_q <= len8;
    en4_q <= len4;
  end

  task automatic push(input bit four, input bit rs, input bit half, input logic [7:0] d, output int n);
    int k;
    if (four) begin v4 = 1'b1; rs4i = rs; half4 = half; d4 = d; end
    else      begin v8 = 1'b1; rs8i = rs; half8 = half; d8 = d; end
    k = 0;
    while (((four ? ready4 : ready8) !== 1'b1) && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) begin total++; bad++; $display("FAIL push_timeout four=%0d", four); end
    @(negedge clk);
    n = cyc;
    v4 = 1'b0;
    v8 = 1'b0;
  endtask

  task automatic wait_idle(input bit four);
    int k;
    k = 0;
    while (((four ? busy4 : busy8) !== 1'b0) && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) begin total++; bad++; $display("FAIL idle_timeout four=%0d", four); end
  endtask

  task automatic wait_rises(input bit four, input int target, input int bound);
    int k;
    k = 0;
    while ((four ? r4_cyc.size() : r8_cyc.size()) < target && k < bound) begin @(negedge clk); k++; end
    if (k >= bound) begin total++; bad++; $display("FAIL rise_timeout four=%0d target=%0d", four, target); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ready8 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready8); end
    total++; if (lrs8 !== 1'b0) begin bad++; $display("FAIL reset_rs got=%b want=0", lrs8); end
    total++; if (lrw8 !== 1'b0) begin bad++; $display("FAIL reset_rw got=%b want=0", lrw8); end
    total++; if (len8 !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", len8); end
    total++; if (ldat8 !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", ldat8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
    total++; if (lvl8 !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", lvl8); end
    total++; if (ldat4 !== 4'h0 || len4 !== 1'b0) begin bad++; $display("FAIL reset_4bit got=%h/%b want=0/0", ldat4, len4); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", ready8); end
    total++; if (ready4 !== 1'b1) begin bad++; $display("FAIL post_reset_ready4 got=%b want=1", ready4); end
  endtask

  task automatic test_char8();
    int   n;
    logic exp_en, exp_busy;
    wait_idle(0);
    push(0, 1'b1, 1'b0, 8'h41, n);
    @(negedge clk);
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL char_busy_early got=%b want=1", busy8); end
    @(negedge clk);
    for (int c = n + 2; c <= n + 41; c++) begin
      exp_en   = (c >= n + 6) && (c <= n + 17);
      exp_busy = (c < n + 18 + T_H + T_EXEC);
      total++; if (lrs8 !== 1'b1 || ldat8 !== 8'h41) begin bad++; $display("FAIL char_pins cyc=+%0d got=%b/%h want=1/41", c - n, lrs8, ldat8); end
      total++; if (len8 !== exp_en) begin bad++; $display("FAIL char_en cyc=+%0d got=%b want=%b", c - n, len8, exp_en); end
      total++; if (busy8 !== exp_busy) begin bad++; $display("FAIL char_busy cyc=+%0d got=%b want=%b", c - n, busy8, exp_busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_gap(input logic [7:0] first, input int wait_len);
    int b, n;
    wait_idle(0);
    b = r8_cyc.size();
    push(0, 1'b0, 1'b0, first, n);
    push(0, 1'b1, 1'b0, 8'h48, n);
    wait_rises(0, b + 2, 400);
    total++; if (r8_dat[b] !== first) begin bad++; $display("FAIL gap_first got=%h want=%h", r8_dat[b], first); end
    total++; if (r8_dat[b+1] !== 8'h48) begin bad++; $display("FAIL gap_second got=%h want=48", r8_dat[b+1]); end
    total++;
    if (r8_cyc[b+1] - f8_cyc[b] != T_H + wait_len + 1 + T_AS) begin
      bad++;
      $display("FAIL gap_len cmd=%h got=%0d want=%0d", first, r8_cyc[b+1] - f8_cyc[b], T_H + wait_len + 1 + T_AS);
    end
    wait_idle(0);
  endtask

  task automatic test_full();
    int b, acc;
    bit take;
    wait_idle(0);
    b = r8_cyc.size();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      v8 = 1'b1; rs8i = 1'b1; half8 = 1'b0; d8 = 8'h60 + 8'(acc);
      take = ready8;
      @(negedge clk);
      if (take) acc++;
    end
    v8 = 1'b0;
    total++; if (acc != 17) begin bad++; $display("FAIL full_accepted got=%0d want=17", acc); end
    total++; if (ready8 !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ready8); end
    total++; if (lvl8 !== 5'd16) begin bad++; $display("FAIL full_level got=%0d want=16", lvl8); end
    wait_rises(0, b + 17, 1500);
    for (int k = 0; k < 17; k++) begin
      total++;
      if (r8_dat[b+k] !== 8'h60 + 8'(k)) begin bad++; $display("FAIL full_order idx=%0d got=%h want=%h", k, r8_dat[b+k], 8'h60 + 8'(k)); end
    end
    wait_idle(0);
  endtask

  task automatic test_level1();
    int b, n, n2;
    wait_idle(0);
    b = r8_cyc.size();
    push(0, 1'b1, 1'b0, 8'h51, n);
    @(negedge clk);
    total++; if (lvl8 !== 5'd1) begin bad++; $display("FAIL lvl1_before got=%0d want=1", lvl8); end
    push(0, 1'b1, 1'b0, 8'h52, n2);
    total++; if (n2 != n + 2) begin bad++; $display("FAIL lvl1_push_edge got=+%0d want=+2", n2 - n); end
    total++; if (lvl8 !== 5'd1) begin bad++; $display("FAIL lvl1_after got=%0d want=1", lvl8); end
    total++; if (ldat8 !== 8'h51) begin bad++; $display("FAIL lvl1_loaded got=%h want=51", ldat8); end
    wait_rises(0, b + 2, 300);
    total++; if (r8_dat[b] !== 8'h51 || r8_dat[b+1] !== 8'h52) begin bad++; $display("FAIL lvl1_order got=%h,%h want=51,52", r8_dat[b], r8_dat[b+1]); end
    wait_idle(0);
  endtask

  task automatic test_4bit();
    int b, n;
    wait_idle(1);
    b = r4_cyc.size();
    push(1, 1'b1, 1'b0, 8'h3C, n);
    wait_rises(1, b + 2, 300);
    total++; if (r4_dat[b] !== 4'h3) begin bad++; $display("FAIL nib_high got=%h want=3", r4_dat[b]); end
    total++; if (r4_dat[b+1] !== 4'hC) begin bad++; $display("FAIL nib_low got=%h want=c", r4_dat[b+1]); end
    total++; if (r4_cyc[b+1] - f4_cyc[b] != T_H + T_AS) begin bad++; $display("FAIL nib_gap got=%0d want=%0d", r4_cyc[b+1] - f4_cyc[b], T_H + T_AS); end
    total++; if (lrs4 !== 1'b1) begin bad++; $display("FAIL nib_rs got=%b want=1", lrs4); end
    wait_idle(1);
    repeat (5) @(negedge clk);
    total++; if (r4_cyc.size() != b + 2) begin bad++; $display("FAIL nib_count got=%0d want=2", r4_cyc.size() - b); end
    b = r4_cyc.size();
    push(1, 1'b0, 1'b1, 8'h30, n);
    wait_idle(1);
    repeat (5) @(negedge clk);
    total++; if (r4_cyc.size() != b + 1) begin bad++; $display("FAIL half_count got=%0d want=1", r4_cyc.size() - b); end
    total++; if (r4_dat[b] !== 4'h3 || lrs4 !== 1'b0) begin bad++; $display("FAIL half_data got=%h/%b want=3/0", r4_dat[b], lrs4); end
  endtask

  task automatic test_reset_mid();
    int b, k;
    wait_idle(0);
    v8 = 1'b1; rs8i = 1'b1; half8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d8 = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    v8 = 1'b0;
    k = 0;
    while (len8 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) begin total++; bad++; $display("FAIL mid_no_pulse"); end
    total++; if (lvl8 !== 5'd3) begin bad++; $display("FAIL mid_queued got=%0d want=3", lvl8); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (len8 !== 1'b0) begin bad++; $display("FAIL mid_en got=%b want=0", len8); end
    total++; if (lvl8 !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", lvl8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy8); end
    rst = 1'b0;
    b = r8_cyc.size();
    repeat (200) @(negedge clk);
    total++; if (r8_cyc.size() != b) begin bad++; $display("FAIL mid_extra_pulses got=%0d want=0", r8_cyc.size() - b); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL mid_busy_late got=%b want=0", busy8); end
  endtask

  initial begin
    test_reset();
    test_char8();
    test_gap(8'h01, T_CLR);
    test_gap(8'h38, T_EXEC);
    test_full();
    test_level1();
    test_4bit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
